// File: rtl/step_pulse_generator.sv
// Registered step-pulse burst generator: emits N fixed-width pulses on command.
// Optional abort input is enabled by defining STEP_PULSE_ABORT_EN.
module step_pulse_generator #(
  parameter int unsigned SIZE        = 4,
  parameter int unsigned HIGH_CYCLES = 500,
  parameter int unsigned LOW_CYCLES  = 500
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [SIZE-1:0] count,
`ifdef STEP_PULSE_ABORT_EN
  input  logic            abort,
`endif
  output logic            busy,
  output logic            done,
  output logic            step,
  output logic [SIZE-1:0] remaining
);

  localparam int unsigned MAX_CYCLES = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int unsigned TW         = $clog2(MAX_CYCLES + 1);
  localparam logic [TW-1:0] HIGH_LOAD = TW'(HIGH_CYCLES - 1);
  localparam logic [TW-1:0] LOW_LOAD  = TW'(LOW_CYCLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic          abortReq;

`ifdef STEP_PULSE_ABORT_EN
  assign abortReq = abort;
`else
  assign abortReq = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      step      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (count != '0) begin
              state     <= HIGH;
              step      <= 1'b1;
              busy      <= 1'b1;
              remaining <= count - 1'b1;
              timer     <= HIGH_LOAD;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        HIGH: begin
          // An abort cuts the pulse short but still runs a full low period.
          if (timer == '0 || abortReq) begin
            state <= LOW;
            step  <= 1'b0;
            timer <= LOW_LOAD;
            if (abortReq) remaining <= '0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        LOW: begin
          if (abortReq) remaining <= '0;
          if (timer == '0) begin
            if (remaining == '0 || abortReq) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= HIGH;
              step      <= 1'b1;
              remaining <= remaining - 1'b1;
              timer     <= HIGH_LOAD;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
